conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder_pkg.sv | 20 ++
 rtl/conv_enc_step.sv | 26 ++
 rtl/conv_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/conv_encoder_pkg.sv
// rtl/conv_encoder_pkg.sv - shared constants, generator defaults and FSM encodings for the K=3 code
package conv_encoder_pkg;

   localparam int K = 3;
   localparam logic [K-1:0] G0_DEFAULT = 3'b111;
   localparam logic [K-1:0] G1_DEFAULT = 3'b101;
   localparam int BYTE_W = 8;
   localparam int CODE_W = 2 * BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_OUTPUT = 2'd2
   } enc_state_e;

   function automatic logic parity3(input logic [K-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/conv_enc_step.sv
// rtl/conv_enc_step.sv - one trellis step: (u, s1, s2) -> coded pair and next shift-register state
module conv_enc_step
   import conv_encoder_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEFAULT,
   parameter logic [K-1:0] G1 = G1_DEFAULT
) (
   input  logic u,
   input  logic s1,
   input  logic s2,
   output logic c0,
   output logic c1,
   output logic next_s1,
   output logic next_s2
);

   logic [K-1:0] window;

   // Tap vector ordering: MSB is the incoming bit, LSB the oldest stored bit.
   assign window  = {u, s1, s2};
   assign c0      = parity3(G0 & window);
   assign c1      = parity3(G1 & window);
   assign next_s1 = u;
   assign next_s2 = s1;

endmodule

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 byte-framed convolutional encoder with ready/valid handshakes
module conv_encoder
   import conv_encoder_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEFAULT,
   parameter logic [K-1:0] G1 = G1_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] data_out,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   enc_state_e        state_r, state_nxt;
   logic [BYTE_W-1:0] byte_r;
   logic              s1_r, s2_r;
   logic [2:0]        bit_cnt_r;
   logic [CODE_W-1:0] code_r;
   logic [15:0]       frame_cnt_r;

   logic u, c0, c1, next_s1, next_s2;

   assign u = byte_r[3'd7 - bit_cnt_r];

   conv_enc_step #(
      .G0(G0),
      .G1(G1)
   ) u_step (
      .u      (u),
      .s1     (s1_r),
      .s2     (s2_r),
      .c0     (c0),
      .c1     (c1),
      .next_s1(next_s1),
      .next_s2(next_s2)
   );

   always_comb begin
      state_nxt = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_ENCODE;
         end
         ST_ENCODE: begin
            busy = 1'b1;
            if (bit_cnt_r == 3'd7) state_nxt = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         byte_r      <= '0;
         s1_r        <= 1'b0;
         s2_r        <= 1'b0;
         bit_cnt_r   <= 3'd0;
         code_r      <= '0;
         frame_cnt_r <= 16'd0;
      end else begin
         state_r <= state_nxt;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  byte_r    <= data_in;
                  s1_r      <= 1'b0;
                  s2_r      <= 1'b0;
                  bit_cnt_r <= 3'd0;
                  code_r    <= '0;
               end
            end
            ST_ENCODE: begin
               // Shifting left lands the first (MSB) pair in the top two bits.
               s1_r      <= next_s1;
               s2_r      <= next_s2;
               bit_cnt_r <= bit_cnt_r + 3'd1;
               code_r    <= {code_r[CODE_W-3:0], c0, c1};
            end
            ST_OUTPUT: begin
               if (out_ready) frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign data_out  = out_valid ? code_r : '0;
   assign frame_cnt = frame_cnt_r;

endmodule
